// File: rtl/hazard_fwd_unit.sv
// Operand forwarding, load-use / mul-div RAW / structural hazard detection and stall control; forwarding and stall are combinational, MD_Done is registered.
// No backpressure input: Stall holds PC and IF/ID and EX_Flush bubbles ID/EX. Optional perf counters are enabled with HAZARD_PERF_CNT_EN.
module hazard_fwd_unit #(
  parameter int RSIZE  = 5,
  parameter int NREAD  = 2,
  parameter int MD_LAT = 4,
  parameter int CNTW   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREAD*RSIZE-1:0] ID_RAddr,
  input  logic [NREAD-1:0]       ID_RUse,
  input  logic                   ID_MDIssue,
  input  logic [RSIZE-1:0]       ID_MDWAddr,
  input  logic [NREAD*RSIZE-1:0] EX_RAddr,
  input  logic [RSIZE-1:0]       EX_WAddr,
  input  logic                   EX_MemRead,
  input  logic                   EX_RFWen,
  input  logic [RSIZE-1:0]       MEM_WAddr,
  input  logic                   MEM_RFWen,
  input  logic [RSIZE-1:0]       WB_WAddr,
  input  logic                   WB_RFWen,
  output logic [2*NREAD-1:0]     EX_FwdSel,
  output logic                   Stall,
  output logic                   EX_Flush,
  output logic                   MD_Busy,
  output logic                   MD_Done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]            StallCnt,
  output logic [15:0]            LUCnt
`endif
);

  logic [CNTW-1:0]  cnt;
  logic [RSIZE-1:0] busy_addr;
  logic             lu_hit;
  logic             sb_hit;
  logic             load_use;
  logic             sb_raw;
  logic             structural;
  logic             issue_ok;

  // MEM is the younger producer, so it wins over WB for the same register.
  always_comb begin
    EX_FwdSel = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (EX_RAddr[i*RSIZE +: RSIZE] == MEM_WAddr && MEM_RFWen && MEM_WAddr != '0)
        EX_FwdSel[2*i +: 2] = 2'd1;
      else if (EX_RAddr[i*RSIZE +: RSIZE] == WB_WAddr && WB_RFWen && WB_WAddr != '0)
        EX_FwdSel[2*i +: 2] = 2'd2;
    end
  end

  always_comb begin
    lu_hit = 1'b0;
    sb_hit = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      if (ID_RUse[i] && ID_RAddr[i*RSIZE +: RSIZE] == EX_WAddr)
        lu_hit = 1'b1;
      if (ID_RUse[i] && ID_RAddr[i*RSIZE +: RSIZE] == busy_addr)
        sb_hit = 1'b1;
    end
  end

  assign MD_Busy    = (cnt != '0);
  assign load_use   = EX_MemRead & EX_RFWen & (EX_WAddr != '0) & lu_hit;
  assign sb_raw     = MD_Busy & (busy_addr != '0) & sb_hit;
  assign structural = ID_MDIssue & MD_Busy;
  assign Stall      = load_use | sb_raw | structural;
  assign EX_Flush   = Stall;
  assign issue_ok   = ID_MDIssue & ~Stall;

  // busy_addr is left stale after completion; MD_Busy masks it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      busy_addr <= '0;
      MD_Done   <= 1'b0;
    end else begin
      MD_Done <= (cnt == CNTW'(1)) & ~issue_ok;
      if (issue_ok) begin
        cnt       <= CNTW'(MD_LAT);
        busy_addr <= ID_MDWAddr;
      end else if (cnt != '0) begin
        cnt <= cnt - CNTW'(1);
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt <= '0;
      LUCnt    <= '0;
    end else begin
      if (Stall && !(&StallCnt))
        StallCnt <= StallCnt + 32'd1;
      if (load_use && !(&LUCnt))
        LUCnt <= LUCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed vector table, multi-cycle scoreboard sequences and randomized reference-model run.
module tb_hazard_fwd_unit;
  localparam int RS  = 5;
  localparam int NR  = 2;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR*RS-1:0] ID_RAddr;
  logic [NR-1:0]   ID_RUse;
  logic            ID_MDIssue;
  logic [RS-1:0]   ID_MDWAddr;
  logic [NR*RS-1:0] EX_RAddr;
  logic [RS-1:0]   EX_WAddr;
  logic            EX_MemRead;
  logic            EX_RFWen;
  logic [RS-1:0]   MEM_WAddr;
  logic            MEM_RFWen;
  logic [RS-1:0]   WB_WAddr;
  logic            WB_RFWen;
  logic [2*NR-1:0] EX_FwdSel;
  logic            Stall;
  logic            EX_Flush;
  logic            MD_Busy;
  logic            MD_Done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]     StallCnt;
  logic [15:0]     LUCnt;
`endif

  hazard_fwd_unit #(.RSIZE(RS), .NREAD(NR), .MD_LAT(LAT), .CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_RAddr(ID_RAddr), .ID_RUse(ID_RUse), .ID_MDIssue(ID_MDIssue), .ID_MDWAddr(ID_MDWAddr),
    .EX_RAddr(EX_RAddr), .EX_WAddr(EX_WAddr), .EX_MemRead(EX_MemRead), .EX_RFWen(EX_RFWen),
    .MEM_WAddr(MEM_WAddr), .MEM_RFWen(MEM_RFWen), .WB_WAddr(WB_WAddr), .WB_RFWen(WB_RFWen),
    .EX_FwdSel(EX_FwdSel), .Stall(Stall), .EX_Flush(EX_Flush), .MD_Busy(MD_Busy), .MD_Done(MD_Done)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCnt(StallCnt), .LUCnt(LUCnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    ID_RAddr = '0; ID_RUse = '0; ID_MDIssue = 1'b0; ID_MDWAddr = '0;
    EX_RAddr = '0; EX_WAddr = '0; EX_MemRead = 1'b0; EX_RFWen = 1'b0;
    MEM_WAddr = '0; MEM_RFWen = 1'b0; WB_WAddr = '0; WB_RFWen = 1'b0;
  endtask

  // Advance to the drive point of the next cycle; checks happen at the following negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [RS-1:0] ex_r0, ex_r1, mem_wa, wb_wa, id_r0, id_r1, ex_wa;
    logic          mem_we, wb_we, ex_mr, ex_we;
    logic [1:0]    ruse;
    logic [3:0]    exp_fwd;
    logic          exp_stall;
  } vec_t;

  vec_t vt[12];

  // Reference model state: scoreboard described by issue cycle, not by a counter.
  int            cyc;
  int            issue_cyc;
  logic [RS-1:0] ref_ba;

  function automatic logic [1:0] ref_sel(input logic [RS-1:0] ra);
    if (MEM_RFWen && MEM_WAddr != 0 && ra == MEM_WAddr) return 2'd1;
    if (WB_RFWen && WB_WAddr != 0 && ra == WB_WAddr) return 2'd2;
    return 2'd0;
  endfunction

  initial begin
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_busy", MD_Busy, 0);
    check("reset_done", MD_Done, 0);
    check("reset_stall", Stall, 0);
    check("reset_flush", EX_Flush, 0);
    check("reset_fwd", EX_FwdSel, 0);
    next_cycle();
    rst_n = 1'b1;

    // ex_r0 ex_r1 mem_wa wb_wa id_r0 id_r1 ex_wa mem_we wb_we ex_mr ex_we ruse fwd stall
    vt[0]  = '{5, 0, 5, 5, 0, 0, 0, 1, 1, 0, 0, 2'b00, 4'b0001, 0};
    vt[1]  = '{5, 0, 5, 5, 0, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0010, 0};
    vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 4'b0000, 0};
    vt[3]  = '{3, 3, 3, 4, 0, 0, 0, 1, 1, 0, 0, 2'b00, 4'b0101, 0};
    vt[4]  = '{4, 3, 3, 4, 0, 0, 0, 1, 1, 0, 0, 2'b00, 4'b0110, 0};
    vt[5]  = '{4, 6, 6, 4, 0, 0, 0, 1, 0, 0, 0, 2'b00, 4'b0100, 0};
    vt[6]  = '{0, 0, 0, 0, 0, 7, 7, 0, 0, 1, 1, 2'b10, 4'b0000, 1};
    vt[7]  = '{0, 0, 0, 0, 0, 7, 7, 0, 0, 1, 1, 2'b01, 4'b0000, 0};
    vt[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b01, 4'b0000, 0};
    vt[9]  = '{0, 0, 0, 0, 0, 7, 7, 0, 0, 1, 0, 2'b10, 4'b0000, 0};
    vt[10] = '{0, 0, 0, 0, 0, 7, 7, 0, 0, 0, 1, 2'b10, 4'b0000, 0};
    vt[11] = '{0, 7, 0, 0, 7, 3, 7, 0, 0, 1, 1, 2'b11, 4'b0000, 1};

    for (int k = 0; k < 12; k++) begin
      idle();
      EX_RAddr  = {vt[k].ex_r1, vt[k].ex_r0};
      MEM_WAddr = vt[k].mem_wa; MEM_RFWen = vt[k].mem_we;
      WB_WAddr  = vt[k].wb_wa;  WB_RFWen  = vt[k].wb_we;
      ID_RAddr  = {vt[k].id_r1, vt[k].id_r0}; ID_RUse = vt[k].ruse;
      EX_WAddr  = vt[k].ex_wa; EX_MemRead = vt[k].ex_mr; EX_RFWen = vt[k].ex_we;
      #2;
      check($sformatf("tbl%0d_fwd", k), EX_FwdSel, vt[k].exp_fwd);
      check($sformatf("tbl%0d_stall", k), Stall, vt[k].exp_stall);
      check($sformatf("tbl%0d_flush", k), EX_Flush, vt[k].exp_stall);
    end

    // Scoreboard RAW: issue r9 at cycle 0, read r9 in cycles 1..5.
    next_cycle(); idle();
    ID_MDIssue = 1'b1; ID_MDWAddr = 9;
    @(negedge clk); check("sb_issue_stall", Stall, 0);
    for (int c = 1; c <= LAT + 1; c++) begin
      next_cycle(); idle();
      ID_RAddr = {5'd0, 5'd9}; ID_RUse = 2'b01;
      @(negedge clk);
      check($sformatf("sb_c%0d_busy", c), MD_Busy, c <= LAT);
      check($sformatf("sb_c%0d_stall", c), Stall, c <= LAT);
      check($sformatf("sb_c%0d_done", c), MD_Done, c == LAT + 1);
    end
    next_cycle(); idle();
    @(negedge clk); check("sb_done_pulse_end", MD_Done, 0);

    // Structural: second issue held in cycles 2..4, accepted in 5, busy 6..9, done 10.
    next_cycle(); idle();
    ID_MDIssue = 1'b1; ID_MDWAddr = 12;
    for (int c = 1; c <= 10; c++) begin
      next_cycle(); idle();
      ID_MDIssue = (c >= 2 && c <= 5); ID_MDWAddr = 13;
      @(negedge clk);
      check($sformatf("st_c%0d_stall", c), Stall, c >= 2 && c <= 4);
      check($sformatf("st_c%0d_busy", c), MD_Busy, c != 5 && c != 10);
      check($sformatf("st_c%0d_done", c), MD_Done, c == 5 || c == 10);
    end

    // Destination r0 occupies the unit but never raises a RAW stall.
    next_cycle(); idle();
    ID_MDIssue = 1'b1; ID_MDWAddr = 0;
    next_cycle(); idle();
    ID_RAddr = '0; ID_RUse = 2'b11;
    @(negedge clk);
    check("r0_busy", MD_Busy, 1);
    check("r0_stall", Stall, 0);
    repeat (LAT + 1) next_cycle();
    idle();

    // Reset mid-op: entry dropped immediately, no MD_Done afterwards.
    next_cycle(); idle();
    ID_MDIssue = 1'b1; ID_MDWAddr = 9;
    next_cycle(); idle();
    @(negedge clk); check("rst_mid_busy_before", MD_Busy, 1);
    next_cycle();
    rst_n = 1'b0;
    #1 check("rst_mid_busy_now", MD_Busy, 0);
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_mid_nodone%0d", c), MD_Done, 0);
      check($sformatf("rst_mid_nobusy%0d", c), MD_Busy, 0);
      next_cycle();
    end

`ifdef HAZARD_PERF_CNT_EN
    do_reset();
    for (int c = 0; c < 3; c++) begin
      idle();
      EX_MemRead = 1'b1; EX_RFWen = 1'b1; EX_WAddr = 7;
      ID_RAddr = {5'd7, 5'd0}; ID_RUse = 2'b10;
      next_cycle();
    end
    idle();
    ID_MDIssue = 1'b1; ID_MDWAddr = 9;
    next_cycle();
    for (int c = 0; c < LAT; c++) begin
      idle();
      ID_RAddr = {5'd0, 5'd9}; ID_RUse = 2'b01;
      next_cycle();
    end
    idle();
    @(negedge clk);
    check("perf_stallcnt", StallCnt, 7);
    check("perf_lucnt", LUCnt, 3);
`endif

    // Randomized run against the issue-cycle reference model.
    do_reset();
    cyc = 0;
    issue_cyc = -100;
    ref_ba = '0;
    for (int n = 0; n < 3000; n++) begin
      logic [RS-1:0] ida[NR];
      logic [RS-1:0] exa[NR];
      logic          m_busy, m_done, m_lu, m_sb, m_st, m_stall;
      logic [2*NR-1:0] m_fwd;
      for (int p = 0; p < NR; p++) begin
        ida[p] = RS'($urandom_range(0, 3));
        exa[p] = RS'($urandom_range(0, 3));
      end
      ID_RAddr   = {ida[1], ida[0]};
      EX_RAddr   = {exa[1], exa[0]};
      ID_RUse    = NR'($urandom);
      ID_MDIssue = ($urandom_range(0, 2) == 0);
      ID_MDWAddr = RS'($urandom_range(0, 3));
      EX_WAddr   = RS'($urandom_range(0, 3));
      EX_MemRead = ($urandom_range(0, 3) == 0);
      EX_RFWen   = 1'($urandom);
      MEM_WAddr  = RS'($urandom_range(0, 3));
      MEM_RFWen  = 1'($urandom);
      WB_WAddr   = RS'($urandom_range(0, 3));
      WB_RFWen   = 1'($urandom);

      m_busy = (cyc - issue_cyc >= 1) && (cyc - issue_cyc <= LAT);
      m_done = (cyc - issue_cyc == LAT + 1);
      m_lu = 1'b0; m_sb = 1'b0;
      for (int p = 0; p < NR; p++) begin
        m_fwd[2*p +: 2] = ref_sel(exa[p]);
        if (ID_RUse[p] && ida[p] == EX_WAddr) m_lu = 1'b1;
        if (ID_RUse[p] && ida[p] == ref_ba) m_sb = 1'b1;
      end
      m_lu    = m_lu & EX_MemRead & EX_RFWen & (EX_WAddr != 0);
      m_sb    = m_sb & m_busy & (ref_ba != 0);
      m_st    = ID_MDIssue & m_busy;
      m_stall = m_lu | m_sb | m_st;

      @(negedge clk);
      check("rnd_fwd", EX_FwdSel, m_fwd);
      check("rnd_stall", Stall, m_stall);
      check("rnd_flush", EX_Flush, m_stall);
      check("rnd_busy", MD_Busy, m_busy);
      check("rnd_done", MD_Done, m_done);
      if (ID_MDIssue && !m_stall) begin
        issue_cyc = cyc;
        ref_ba = ID_MDWAddr;
      end
      cyc++;
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
